// File: rtl/fetch_pkg.sv
// Shared definitions for the dual-issue fetch sequencer: FSM encoding,
// default sequential step / reset PC, and the target alignment constant.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_STEP     = 8;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Redirect targets are word aligned: this many low bits are forced to zero.
  localparam int unsigned ALIGN_LSBS   = 2;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between the hazard unit / decode (master side) and the fetch sequencer
// (slave side), plus the observed fetch PC, strobes and debug state.
interface fetch_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  import fetch_pkg::*;

  // redirN_valid is a single-cycle qualifier for redirN_target with no ready
  // back: the sequencer always accepts it (applied now, latched while stallf
  // is high, or dropped during BOOT). stallf is the only back-pressure.
  logic             stallf;
  logic             redir0_valid;
  logic [WIDTH-1:0] redir0_target;
  logic             redir1_valid;
  logic [WIDTH-1:0] redir1_target;
  logic [WIDTH-1:0] pcf;
  logic             fetch_valid;
  logic             flushd;
  logic             kill1d;
  logic [CNT_W-1:0] redirect_count;
  fetch_state_e     dbg_state;

  modport master (
    output stallf, redir0_valid, redir0_target, redir1_valid, redir1_target,
    input  pcf, fetch_valid, flushd, kill1d, redirect_count, dbg_state
  );

  modport slave (
    input  stallf, redir0_valid, redir0_target, redir1_valid, redir1_target,
    output pcf, fetch_valid, flushd, kill1d, redirect_count, dbg_state
  );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Combinational redirect arbiter: slot 0 beats slot 1, targets are aligned,
// and a live redirect beats a previously latched (pending) one.
module redirect_arb
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             r0_valid,
  input  logic [WIDTH-1:0] r0_target,
  input  logic             r1_valid,
  input  logic [WIDTH-1:0] r1_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  output logic             live_valid,
  output logic [WIDTH-1:0] live_target,
  output logic             apply_valid,
  output logic [WIDTH-1:0] apply_target
);

  localparam logic [WIDTH-1:0] ALIGN_MASK =
    {{(WIDTH - ALIGN_LSBS){1'b1}}, {ALIGN_LSBS{1'b0}}};

  logic [WIDTH-1:0] raw_target;

  always_comb begin
    raw_target   = r0_valid ? r0_target : r1_target;
    live_valid   = r0_valid | r1_valid;
    live_target  = raw_target & ALIGN_MASK;
    // Pending targets were aligned when latched, so they pass straight through.
    apply_valid  = live_valid | pend_valid;
    apply_target = live_valid ? live_target : pend_target;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, the BOOT/RUN/HOLD FSM, the
// stalled-redirect latch and the saturating applied-redirect counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int unsigned      STEP     = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int               CNT_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fv_q, fv_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush;
  logic             kill;

  logic             live_valid;
  logic [WIDTH-1:0] live_target;
  logic             apply_valid;
  logic [WIDTH-1:0] apply_target;

  redirect_arb #(.WIDTH(WIDTH)) u_arb (
    .r0_valid     (bus.redir0_valid),
    .r0_target    (bus.redir0_target),
    .r1_valid     (bus.redir1_valid),
    .r1_target    (bus.redir1_target),
    .pend_valid   (pend_valid_q),
    .pend_target  (pend_target_q),
    .live_valid   (live_valid),
    .live_target  (live_target),
    .apply_valid  (apply_valid),
    .apply_target (apply_target)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    cnt_d         = cnt_q;
    flush         = 1'b0;
    kill          = bus.redir0_valid & ~bus.stallf & ~reset;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (bus.stallf)  state_d = ST_HOLD;
      ST_HOLD: if (!bus.stallf) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    // BOOT ignores redirects entirely; otherwise stallf decides apply vs latch.
    if (state_q != ST_BOOT && !reset) begin
      if (!bus.stallf) begin
        if (apply_valid) begin
          flush        = 1'b1;
          pc_d         = apply_target;
          pend_valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          pc_d = pc_q + WIDTH'(STEP);
        end
      end else if (live_valid) begin
        pend_valid_d  = 1'b1;
        pend_target_d = live_target;
      end
    end

    fv_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fv_q          <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fv_q          <= fv_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.pcf            = pc_q;
  assign bus.fetch_valid    = fv_q;
  assign bus.flushd         = flush;
  assign bus.kill1d         = kill;
  assign bus.redirect_count = cnt_q;
  assign bus.dbg_state      = state_q;

endmodule
